// File: rtl/present_pkg.sv
// Shared PRESENT definitions: block geometry, the 4-bit S-box table and
// the serial S-layer FSM state encoding.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int NIBBLES = 16;

  // Forward S-box, indexed by the input nibble.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/present_sbox4.sv
// Combinational PRESENT 4-bit S-box lookup.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = SBOX[nib_i];

endmodule

// File: rtl/present_slayer_serial.sv
// Serial PRESENT addRoundKey + S-layer: NPC nibbles substituted per cycle,
// result offered downstream over valid/ready.
module present_slayer_serial
  import present_pkg::*;
#(
  parameter int NPC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_block,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               busy,
  output state_e             state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready never looks at valid, and clear overrides any transfer.

  localparam int STEPS = NIBBLES / NPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SUB_W = 4 * NPC;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
    $error("present_slayer_serial: NPC must be 1, 2, 4, 8 or 16");
  end

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUB_W-1:0]   sub;
  logic [BLOCK_W-1:0] rot;

  for (genvar i = 0; i < NPC; i++) begin : g_sbox
    present_sbox4 u_sbox (
      .nib_i(data_q[4*i +: 4]),
      .nib_o(sub[4*i +: 4])
    );
  end

  // Substituted nibbles re-enter at the top so a full pass restores order.
  if (NPC == NIBBLES) begin : g_full
    assign rot = sub;
  end else begin : g_rot
    assign rot = {sub, data_q[BLOCK_W-1:SUB_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      data_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_d  = in_block ^ in_key;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          data_d = rot;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_d  = in_block ^ in_key;
              cnt_d   = '0;
              state_d = BUSY;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign out_block = (state_q == DONE) ? data_q : '0;
  assign busy      = (state_q == BUSY);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_present_slayer_serial.sv
// Bench for present_slayer_serial: main instance at NPC=1 with a scoreboard,
// plus an NPC=4 instance for the four-cycle known-answer vector.
module tb_present_slayer_serial;
  import present_pkg::*;

  localparam int NPC = 1;
  localparam int LAT = 16 / NPC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_block;
  state_e      state_dbg;

  logic        in_valid4 = 1'b0;
  logic [63:0] in_block4 = 64'h0123_4567_89AB_CDEF;
  logic        in_ready4, out_valid4, busy4;
  logic [63:0] out_block4;
  state_e      state_dbg4;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [63:0] exp_q[$];
  int unsigned lat_q[$];
  bit          fresh = 1'b1;
  bit          rand_bp = 1'b0;

  logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  present_slayer_serial #(.NPC(NPC)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .busy(busy), .state_dbg(state_dbg)
  );

  present_slayer_serial #(.NPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_block(in_block4), .in_key(64'h0),
    .out_valid(out_valid4), .out_ready(1'b1), .out_block(out_block4),
    .busy(busy4), .state_dbg(state_dbg4)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [63:0] b, input logic [63:0] k);
    logic [63:0] x;
    logic [63:0] r;
    x = b ^ k;
    r = '0;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb[x[4*i +: 4]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] b, input logic [63:0] k);
    int t;
    t = 0;
    in_block = b;
    in_key   = k;
    in_valid = 1'b1;
    @(negedge clk);
    while (!(in_ready && !clear) && t <= 500) begin
      t++;
      @(negedge clk);
    end
    if (t > 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(model(b, k));
      lat_q.push_back(cyc + 1 + LAT);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
    in_key   = {$urandom, $urandom};
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    #1;
  endtask

  task automatic flush();
    exp_q.delete();
    lat_q.delete();
    fresh = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected no output", out_block);
      end else begin
        if (fresh && lat_q.size() != 0) begin
          chk("latency", 64'(cyc), 64'(lat_q[0]));
          void'(lat_q.pop_front());
          fresh = 1'b0;
        end
        chk("out_block", out_block, exp_q[0]);
        chk("busy_in_done", 64'(busy), 64'(0));
        if (!out_ready) chk("in_ready_stall", 64'(in_ready), 64'(0));
        if (out_ready) begin
          void'(exp_q.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int a;
    logic [63:0] b;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_out_block", out_block, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;

    // NPC=4 known-answer vector and four-cycle latency.
    in_valid4 = 1'b1;
    @(negedge clk);
    chk("npc4_in_ready", 64'(in_ready4), 64'(1));
    a = int'(cyc) + 1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    t = 0;
    @(negedge clk);
    while (!out_valid4 && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("npc4_latency", 64'(cyc), 64'(a + 4));
    chk("npc4_out_block", out_block4, model(64'h0123_4567_89AB_CDEF, 64'h0));
    @(posedge clk);
    #1;

    // Directed vectors.
    out_ready = 1'b1;
    send(64'h0, 64'h0);
    drain();
    send(64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();
    send(64'h0123_4567_89AB_CDEF, 64'h0);
    drain();

    // Back-pressure then back-to-back accept in the releasing cycle.
    out_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom});
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1;
    b = {$urandom, $urandom};
    in_block  = b;
    in_key    = 64'h5A5A_0F0F_3C3C_9696;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_out_valid", 64'(out_valid), 64'(1));
    chk("b2b_in_ready", 64'(in_ready), 64'(1));
    exp_q.push_back(model(b, 64'h5A5A_0F0F_3C3C_9696));
    lat_q.push_back(cyc + 1 + LAT);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
    drain();

    // Clear at BUSY cycle 5 with a competing in_valid.
    send({$urandom, $urandom}, {$urandom, $urandom});
    repeat (4) @(posedge clk);
    #1;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_block = {$urandom, $urandom};
    flush();
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", 64'(busy), 64'(0));
    chk("clear_out_valid", 64'(out_valid), 64'(0));
    chk("clear_in_ready", 64'(in_ready), 64'(1));
    repeat (20) @(posedge clk);
    #1;
    send({$urandom, $urandom}, {$urandom, $urandom});
    drain();

    // Asynchronous reset mid-BUSY.
    send({$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_out_block", out_block, 64'h0);
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444);
    drain();

    // Randomized traffic with random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom});
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
